// File: rtl/serial_word_rx_pkg.sv
// Shared types and sizing helpers for the bit-serial result receiver.
package serial_word_rx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // A frame carries the D_W sum bits followed by one carry bit.
   function automatic int frame_w(input int d_w);
      return d_w + 1;
   endfunction

endpackage

// File: rtl/serial_word_rx_if.sv
// Serial-in / parallel-out handshake bundle between the serial source, the receiver and its consumer.
interface serial_word_rx_if #(
   parameter int D_W = 4
) ();

   logic           ser_valid;
   logic           ser_start;
   logic           ser_bit;
   logic [D_W-1:0] par_sum;
   logic           par_cout;
   logic           par_valid;
   logic           par_ready;
   logic           overrun;
   logic           frame_err;
   logic           busy;

   modport master (
      output ser_valid, ser_start, ser_bit, par_ready,
      input  par_sum, par_cout, par_valid, overrun, frame_err, busy
   );

   modport slave (
      input  ser_valid, ser_start, ser_bit, par_ready,
      output par_sum, par_cout, par_valid, overrun, frame_err, busy
   );

endinterface

// File: rtl/serial_word_rx_sipo_shift.sv
// Serial-in parallel-out register: new bits enter at the MSB and the contents move toward bit 0.
module sipo_shift #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic         i_bit,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;
   logic [W-1:0] w_base;

   // Clear and shift together start a fresh frame with its first bit already loaded.
   assign w_base = i_clr ? '0 : r_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= {i_bit, w_base[W-1:1]};
      end else if (i_clr) begin
         r_q <= '0;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/serial_word_rx.sv
// Rebuilds an LSB-first serial sum+carry frame into a parallel word behind a valid/ready handshake.
module serial_word_rx
   import serial_word_rx_pkg::*;
#(
   parameter int D_W = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   serial_word_rx_if.slave bus
);

   localparam int FRAME_W = frame_w(D_W);
   localparam int CNT_W   = $clog2(FRAME_W + 1);

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_count;
   logic               r_overrun;
   logic               r_frame_err;
   logic [FRAME_W-1:0] w_sr;
   logic               w_hs;
   logic               w_start;
   logic               w_last;
   logic               w_clr;
   logic               w_shift;
   logic               w_abort;
   logic               w_drop;

   assign w_hs    = (r_state == HOLD) & bus.par_ready;
   assign w_start = bus.ser_valid & bus.ser_start;
   assign w_last  = (r_count == CNT_W'(FRAME_W - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_start) w_next = SHIFT;
         SHIFT:   if (bus.ser_valid & ~bus.ser_start & w_last) w_next = HOLD;
         HOLD:    if (w_hs) w_next = w_start ? SHIFT : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // A start seen in SHIFT always aborts: the frame cannot be complete yet.
   always_comb begin
      w_clr   = 1'b0;
      w_shift = 1'b0;
      w_abort = 1'b0;
      w_drop  = 1'b0;
      case (r_state)
         IDLE: begin
            w_clr   = w_start;
            w_shift = w_start;
         end
         SHIFT: begin
            w_clr   = w_start;
            w_shift = bus.ser_valid;
            w_abort = w_start;
         end
         HOLD: begin
            w_clr   = w_hs & w_start;
            w_shift = w_hs & w_start;
            w_drop  = bus.ser_valid & ~bus.par_ready;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (w_clr) begin
         r_count <= CNT_W'(1);
      end else if (w_shift) begin
         r_count <= w_last ? '0 : r_count + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_overrun   <= w_hs ? 1'b0 : (r_overrun | w_drop);
         r_frame_err <= w_abort;
      end
   end

   sipo_shift #(.W(FRAME_W)) u_sipo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (w_clr),
      .i_en    (w_shift),
      .i_bit   (bus.ser_bit),
      .o_q     (w_sr)
   );

   assign bus.par_sum   = w_sr[D_W-1:0];
   assign bus.par_cout  = w_sr[D_W];
   assign bus.par_valid = (r_state == HOLD);
   assign bus.busy      = (r_state == SHIFT);
   assign bus.overrun   = r_overrun;
   assign bus.frame_err = r_frame_err;

endmodule
